// File: rtl/adder_serial_nbit.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry processes one
// operand bit per clock, LSB first, and reports sum/difference, carry-out and signed overflow.
module adder_serial_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              c_q, c_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic bit_a, bit_b, sum_bit, carry_bit, accept;

    always_comb begin
        bit_a     = a_q[cnt_q];
        bit_b     = b_q[cnt_q];
        sum_bit   = bit_a ^ bit_b ^ c_q;
        carry_bit = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
        accept    = start && (state_q != StRun);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StRun: begin
                c_d            = carry_bit;
                res_d          = res_q >> 1;
                res_d[WIDTH-1] = sum_bit;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    out_d   = res_d;
                    cout_d  = carry_bit;
                    // c_q is the carry into the MSB on the last bit
                    ovf_d   = c_q ^ carry_bit;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Subtraction is in1 + ~in2 + 1, with the +1 supplied as the initial carry
        if (accept) begin
            a_d     = in1;
            b_d     = sub ? ~in2 : in2;
            c_d     = sub;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule
